// File: rtl/control_fsm_multicycle.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/writeback sequencing with memory stall timeout trap.
// Optional retired-instruction counter output `instret` enabled by defining CTRL_PERF_COUNTER_EN.
module control_fsm_multicycle #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned WAIT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_update,
  output logic       branch,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       fault
`ifdef CTRL_PERF_COUNTER_EN
  ,
  output logic [31:0] instret
`endif
);

  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_OPIMM = 7'd19;
  localparam logic [6:0] OP_STORE = 7'd35;
  localparam logic [6:0] OP_OP    = 7'd51;
  localparam logic [6:0] OP_BEQ   = 7'd99;
  localparam logic [6:0] OP_JAL   = 7'd111;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] stall_cnt;
  logic              stall_state;
  logic              timeout_hit;

  assign stall_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !mem_ready &&
                       (stall_cnt == WAIT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if ((state_next != state) || mem_ready || !stall_state)
      stall_cnt <= '0;
    else
      stall_cnt <= stall_cnt + WAIT_W'(1);
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    fault      = 1'b0;
    case (state)
      S_RESET: state_next = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        if (mem_ready)        state_next = S_DECODE;
        else if (timeout_hit) state_next = S_TRAP;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_OP:             state_next = S_EXECUTER;
          OP_OPIMM:          state_next = S_EXECUTEI;
          OP_BEQ:            state_next = S_BEQ;
          OP_JAL:            state_next = S_JAL;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (opcode == OP_LOAD)       state_next = S_MEMREAD;
        else if (opcode == OP_STORE) state_next = S_MEMWRITE;
        else                         state_next = S_TRAP;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)        state_next = S_MEMWB;
        else if (timeout_hit) state_next = S_TRAP;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready)        state_next = S_FETCH;
        else if (timeout_hit) state_next = S_TRAP;
      end
      S_EXECUTER: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_TRAP:  fault = 1'b1;
      default: state_next = S_TRAP;
    endcase
  end

  // Decoded from opcode in every active state; held at 0 in RESET and TRAP.
  always_comb begin
    imm_src = 3'b000;
    if ((state != S_RESET) && (state != S_TRAP)) begin
      case (opcode)
        OP_STORE: imm_src = 3'b001;
        OP_BEQ:   imm_src = 3'b010;
        OP_JAL:   imm_src = 3'b011;
        default:  imm_src = 3'b000;
      endcase
    end
  end

`ifdef CTRL_PERF_COUNTER_EN
  logic retire;

  assign retire = (state_next == S_FETCH) &&
                  ((state == S_MEMWB) || (state == S_ALUWB) ||
                   (state == S_BEQ)   || (state == S_MEMWRITE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + 32'd1;
  end
`endif

endmodule
